// File: rtl/level_sync_multi_pkg.sv
// Shared constants and FSM state encoding for the level_sync_multi block.
package level_sync_multi_pkg;

    // Default parameter values for the top and its run counters
    localparam int DEF_SAMPLES_PER_WORD = 2;
    localparam int DEF_SAMPLE_W         = 16;
    localparam int DEF_CNT_W            = 32;
    localparam int DEF_SIGNED_MODE      = 1;
    localparam int DEF_ABS_MODE         = 0;

    // State encodings kept as plain constants so older code can use them directly
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE
    } state_e;

endpackage

// File: rtl/level_sync_multi_if.sv
// Sample-stream interface: packed ADC words in, registered words plus packet flag out.
interface level_sync_multi_if
    import level_sync_multi_pkg::*;
#(
    parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
    parameter int SAMPLE_W         = DEF_SAMPLE_W
);
    logic                                 adc_valid;
    logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] adc_data;
    logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] data_out;
    logic                                 data_valid;
    logic                                 sync;

    // Source of ADC words and consumer of the tagged output stream
    modport master (
        output adc_valid, adc_data,
        input  data_out, data_valid, sync
    );

    // The level_sync_multi block itself
    modport slave (
        input  adc_valid, adc_data,
        output data_out, data_valid, sync
    );
endinterface

// File: rtl/level_run_cnt.sv
// Per-word threshold qualification and run-length update for one direction
// (GREATER=1: sample > threshold, GREATER=0: sample < threshold). Purely
// combinational; the owning block holds the counter register.
module level_run_cnt #(
    parameter int N           = 2,
    parameter int W           = 16,
    parameter int CNT_W       = 32,
    parameter int SIGNED_MODE = 1,
    parameter int ABS_MODE    = 0,
    parameter int GREATER     = 1
) (
    input  logic [N*W-1:0]   samples_i,
    input  logic [W-1:0]     threshold_i,
    input  logic [CNT_W-1:0] run_i,
    output logic [CNT_W-1:0] run_o
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N-1:0]        qual;
    logic signed [W:0]   thr_ext;
    logic [CNT_W:0]      sum;
    logic [CNT_W-1:0]    trail;
    logic                brk;

    // One extra bit lets signed and unsigned operands share a single signed compare
    assign thr_ext = (SIGNED_MODE != 0) ? {threshold_i[W-1], threshold_i}
                                        : {1'b0, threshold_i};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_qual
            logic [W-1:0]      raw;
            logic signed [W:0] ext;
            logic signed [W:0] mag;

            assign raw = samples_i[gi*W +: W];

            // Magnitude folding: the most negative code saturates to the max positive code
            always_comb begin
                ext = (SIGNED_MODE != 0) ? {raw[W-1], raw} : {1'b0, raw};
                mag = ext;
                if (SIGNED_MODE != 0 && ABS_MODE != 0 && raw[W-1]) begin
                    if (raw == {1'b1, {(W-1){1'b0}}}) begin
                        mag = {2'b00, {(W-1){1'b1}}};
                    end else begin
                        mag = -ext;
                    end
                end
            end

            assign qual[gi] = (GREATER != 0) ? (mag > thr_ext) : (mag < thr_ext);
        end
    endgenerate

    // Extend the run on a fully qualifying word, else restart from the newest samples
    always_comb begin
        sum   = {1'b0, run_i} + (CNT_W+1)'(N);
        trail = '0;
        brk   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!brk && qual[i]) begin
                trail = trail + ONE;
            end else begin
                brk = 1'b1;
            end
        end
        if (&qual) begin
            run_o = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else begin
            run_o = trail;
        end
    end

endmodule

// File: rtl/level_sync_multi.sv
// Level-triggered packet framing over a multi-sample ADC stream. A packet opens
// once enough consecutive samples exceed the start threshold and closes once
// enough consecutive samples fall below the stop threshold; sync flags the
// words belonging to the packet.
// Optional feature: define LEVEL_SYNC_MULTI_PKT_CNT_EN to add a 32-bit
// wrapping pkt_count output counting packet starts.
module level_sync_multi
    import level_sync_multi_pkg::*;
#(
    parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
    parameter int SAMPLE_W         = DEF_SAMPLE_W,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int SIGNED_MODE      = DEF_SIGNED_MODE,
    parameter int ABS_MODE         = DEF_ABS_MODE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [SAMPLE_W-1:0]   start_threshold,
    input  logic [SAMPLE_W-1:0]   stop_threshold,
    input  logic [CNT_W-1:0]      start_samples_number,
    input  logic [CNT_W-1:0]      stop_samples_number,
`ifdef LEVEL_SYNC_MULTI_PKT_CNT_EN
    output logic [31:0]           pkt_count,
`endif
    level_sync_multi_if.slave     sif
);
    localparam int DW = SAMPLES_PER_WORD * SAMPLE_W;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] start_run_q, start_run_d;
    logic [CNT_W-1:0] stop_run_q, stop_run_d;
    logic [CNT_W-1:0] start_upd, stop_upd;
    logic [CNT_W-1:0] start_num_eff, stop_num_eff;
    logic [DW-1:0]    data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             sync_q, sync_d;

    // A requested run length of zero would fire without any qualifying sample
    assign start_num_eff = (start_samples_number == '0) ? ONE : start_samples_number;
    assign stop_num_eff  = (stop_samples_number  == '0) ? ONE : stop_samples_number;

    level_run_cnt #(
        .N(SAMPLES_PER_WORD), .W(SAMPLE_W), .CNT_W(CNT_W),
        .SIGNED_MODE(SIGNED_MODE), .ABS_MODE(ABS_MODE), .GREATER(1)
    ) u_start_run (
        .samples_i   (sif.adc_data),
        .threshold_i (start_threshold),
        .run_i       (start_run_q),
        .run_o       (start_upd)
    );

    level_run_cnt #(
        .N(SAMPLES_PER_WORD), .W(SAMPLE_W), .CNT_W(CNT_W),
        .SIGNED_MODE(SIGNED_MODE), .ABS_MODE(ABS_MODE), .GREATER(0)
    ) u_stop_run (
        .samples_i   (sif.adc_data),
        .threshold_i (stop_threshold),
        .run_i       (stop_run_q),
        .run_o       (stop_upd)
    );

    // Next-state: only valid words advance the FSM; both runs restart on any transition
    always_comb begin
        state_d      = state_q;
        start_run_d  = start_run_q;
        stop_run_d   = stop_run_q;
        sync_d       = sync_q;
        data_valid_d = sif.adc_valid;
        data_out_d   = sif.adc_valid ? sif.adc_data : data_out_q;
        if (!en) begin
            state_d     = S_IDLE;
            start_run_d = '0;
            stop_run_d  = '0;
            sync_d      = 1'b0;
        end else if (sif.adc_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (start_upd >= start_num_eff) begin
                        state_d     = S_ACTIVE;
                        start_run_d = '0;
                        stop_run_d  = '0;
                    end else begin
                        start_run_d = start_upd;
                    end
                end
                S_ACTIVE: begin
                    if (stop_upd >= stop_num_eff) begin
                        state_d     = S_IDLE;
                        start_run_d = '0;
                        stop_run_d  = '0;
                    end else begin
                        stop_run_d = stop_upd;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            sync_d = (state_d == S_ACTIVE);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_run_q  <= '0;
            stop_run_q   <= '0;
            sync_q       <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_run_q  <= start_run_d;
            stop_run_q   <= stop_run_d;
            sync_q       <= sync_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    assign sif.data_out   = data_out_q;
    assign sif.data_valid = data_valid_q;
    assign sif.sync       = sync_q;

`ifdef LEVEL_SYNC_MULTI_PKT_CNT_EN
    logic [31:0] pkt_count_q;
    logic        pkt_start;

    assign pkt_start = (state_q == S_IDLE) && (state_d == S_ACTIVE);

    // Packet-start counter; survives en=0, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (pkt_start) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_level_sync_multi.sv
// Self-checking bench for level_sync_multi: scoreboard of expected output words
// (data, sync, arrival cycle) plus scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_level_sync_multi;
    import level_sync_multi_pkg::*;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int CW = 32;
    localparam int DW = N * W;

    typedef struct {
        logic [DW-1:0] data;
        logic          sync;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [W-1:0]  start_thr, stop_thr;
    logic [CW-1:0] start_num, stop_num;
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    level_sync_multi_if #(.SAMPLES_PER_WORD(N), .SAMPLE_W(W)) m_if ();
    level_sync_multi_if #(.SAMPLES_PER_WORD(N), .SAMPLE_W(W)) a_if ();

`ifdef LEVEL_SYNC_MULTI_PKT_CNT_EN
    logic [31:0] pkt_count;
    logic [31:0] a_pkt_count;
`endif

    level_sync_multi #(
        .SAMPLES_PER_WORD(N), .SAMPLE_W(W), .CNT_W(CW), .SIGNED_MODE(1), .ABS_MODE(0)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .en                   (en),
        .start_threshold      (start_thr),
        .stop_threshold       (stop_thr),
        .start_samples_number (start_num),
        .stop_samples_number  (stop_num),
`ifdef LEVEL_SYNC_MULTI_PKT_CNT_EN
        .pkt_count            (pkt_count),
`endif
        .sif                  (m_if)
    );

    level_sync_multi #(
        .SAMPLES_PER_WORD(N), .SAMPLE_W(W), .CNT_W(CW), .SIGNED_MODE(1), .ABS_MODE(1)
    ) dut_abs (
        .clk                  (clk),
        .reset                (reset),
        .en                   (en),
        .start_threshold      (start_thr),
        .stop_threshold       (stop_thr),
        .start_samples_number (start_num),
        .stop_samples_number  (stop_num),
`ifdef LEVEL_SYNC_MULTI_PKT_CNT_EN
        .pkt_count            (a_pkt_count),
`endif
        .sif                  (a_if)
    );

    // Scoreboard consumer: every output word must match the oldest expectation, one cycle late
    always @(negedge clk) begin : monitor
        exp_t e;
        if (m_if.data_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h sync=%b, required no output", m_if.data_out, m_if.sync);
            end else begin
                e = sb_q.pop_front();
                if (m_if.data_out !== e.data || m_if.sync !== e.sync || cyc != e.cyc + 1) begin
                    errors++;
                    $display("FAIL word: got data=%h sync=%b cyc=%0d, required data=%h sync=%b cyc=%0d",
                             m_if.data_out, m_if.sync, cyc, e.data, e.sync, e.cyc + 1);
                end else begin
                    $display("word data=%h sync=%b cyc=%0d ok", m_if.data_out, m_if.sync, cyc);
                end
            end
        end
    end

    // Drive one valid word (s0 oldest) and queue its expected output
    task automatic send(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic exp_sync);
        exp_t e;
        m_if.adc_data  = {s1, s0};
        m_if.adc_valid = 1'b1;
        e.data = {s1, s0};
        e.sync = exp_sync;
        e.cyc  = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        m_if.adc_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [W-1:0] sta_t, input logic [CW-1:0] sta_n,
                           input logic [W-1:0] sto_t, input logic [CW-1:0] sto_n);
        start_thr = sta_t;
        start_num = sta_n;
        stop_thr  = sto_t;
        stop_num  = sto_n;
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (m_if.data_valid !== 1'b0 || m_if.sync !== 1'b0 || m_if.data_out !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b sync=%b data=%h, required 0 0 0",
                     name, m_if.data_valid, m_if.sync, m_if.data_out);
        end else begin
            $display("%s outputs zero ok", name);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must win over en and a valid qualifying word
        en             = 1'b1;
        m_if.adc_data  = {16'd200, 16'd200};
        m_if.adc_valid = 1'b1;
        reset          = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("reset_dominates");
        m_if.adc_valid = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic test_start_run();
        set_cfg(16'd100, 4, 16'd10, 3);
        send(16'd200, 16'd200, 1'b0);
        send(16'd200, 16'd200, 1'b1);
        send(16'd5,   16'd5,   1'b1);
        send(16'd5,   16'd5,   1'b0);
        send(16'd50,  16'd200, 1'b0);
        send(16'd200, 16'd200, 1'b0);
        send(16'd200, 16'd200, 1'b1);
    endtask

    task automatic test_stop_run();
        send(16'd5,  16'd5, 1'b1);
        send(16'd20, 16'd5, 1'b1);
        send(16'd5,  16'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Config changes mid-run keep the run; transition word never counts for the new state
        set_cfg(16'd100, 4, 16'd10, 3);
        send(16'd200, 16'd200, 1'b0);
        set_cfg(16'd150, 4, 16'd300, 4);
        send(16'd200, 16'd200, 1'b1);
        send(16'd200, 16'd200, 1'b1);
        send(16'd200, 16'd200, 1'b0);
        send(16'd200, 16'd200, 1'b0);
        set_cfg(16'd100, 4, 16'd10, 3);
    endtask

    task automatic test_gaps_and_enable();
        send(16'd0, 16'd0, 1'b0);
        send(16'd200, 16'd200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (m_if.data_valid !== 1'b0 || m_if.sync !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle: got valid=%b sync=%b, required 0 0", m_if.data_valid, m_if.sync);
            end
        end
        send(16'd200, 16'd200, 1'b1);
        send(16'd5, 16'd5, 1'b1);
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        checks++;
        if (m_if.sync !== 1'b0) begin
            errors++;
            $display("FAIL en_low_sync: got sync=%b, required 0", m_if.sync);
        end else begin
            $display("en_low sync=0 ok");
        end
        send(16'd200, 16'd200, 1'b0);
        send(16'd200, 16'd200, 1'b1);
        send(16'd5, 16'd5, 1'b1);
        en = 1'b0;
        send(16'd7, 16'd7, 1'b0);
        en = 1'b1;
        send(16'd200, 16'd200, 1'b0);
        send(16'd200, 16'd200, 1'b1);
        send(16'd5, 16'd5, 1'b1);
        send(16'd5, 16'd5, 1'b0);
    endtask

    task automatic test_reset_active();
        set_cfg(16'd100, 2, 16'd10, 3);
        send(16'd200, 16'd200, 1'b1);
        pulse_reset();
        check_zero_outputs("reset_in_active");
        set_cfg(16'd100, 0, 16'd10, 3);
        send(16'd200, 16'd50, 1'b0);
        send(16'd50, 16'd200, 1'b1);
    endtask

    task automatic test_abs();
        pulse_reset();
        // Most negative sample must saturate to 32767, which is not above 32767
        set_cfg(16'h7FFF, 1, 16'd10, 3);
        a_if.adc_data  = {16'h8000, 16'h8000};
        a_if.adc_valid = 1'b1;
        send(16'h8000, 16'h8000, 1'b0);
        a_if.adc_valid = 1'b0;
        checks++;
        if (a_if.data_valid !== 1'b1 || a_if.sync !== 1'b0) begin
            errors++;
            $display("FAIL abs_saturate: got valid=%b sync=%b, required 1 0", a_if.data_valid, a_if.sync);
        end else begin
            $display("abs saturate word sync=0 ok");
        end
        set_cfg(16'd1000, 2, 16'd10, 3);
        a_if.adc_data  = {16'h8000, 16'hF830};
        a_if.adc_valid = 1'b1;
        send(16'hF830, 16'h8000, 1'b0);
        a_if.adc_valid = 1'b0;
        checks++;
        if (a_if.data_valid !== 1'b1 || a_if.sync !== 1'b1 || a_if.data_out !== {16'h8000, 16'hF830}) begin
            errors++;
            $display("FAIL abs_start: got valid=%b sync=%b data=%h, required 1 1 8000f830",
                     a_if.data_valid, a_if.sync, a_if.data_out);
        end else begin
            $display("abs start word sync=1 ok");
        end
    endtask

    task automatic test_pkt_count();
`ifdef LEVEL_SYNC_MULTI_PKT_CNT_EN
        pulse_reset();
        set_cfg(16'd100, 1, 16'd10, 1);
        for (int p = 0; p < 3; p++) begin
            send(16'd200, 16'd200, 1'b1);
            send(16'd5, 16'd5, 1'b0);
        end
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        checks++;
        if (pkt_count !== 32'd3) begin
            errors++;
            $display("FAIL pkt_count_three: got %0d, required 3", pkt_count);
        end else begin
            $display("pkt_count=3 ok");
        end
        pulse_reset();
        checks++;
        if (pkt_count !== 32'd0) begin
            errors++;
            $display("FAIL pkt_count_reset: got %0d, required 0", pkt_count);
        end else begin
            $display("pkt_count reset ok");
        end
`endif
    endtask

    initial begin
        reset          = 1'b1;
        en             = 1'b1;
        m_if.adc_valid = 1'b0;
        m_if.adc_data  = '0;
        a_if.adc_valid = 1'b0;
        a_if.adc_data  = '0;
        set_cfg(16'd100, 4, 16'd10, 3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_start_run();
        test_stop_run();
        test_back_to_back();
        test_gaps_and_enable();
        test_reset_active();
        test_abs();
        test_pkt_count();

        @(posedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_words: got %0d words outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
